// File: rtl/i2c_slave_rx_sequencer.sv
// I2C slave receive sequencer: drives the bit/byte reader and ACK writer through
// address match, data reception with valid/ready handoff, and read handoff to TX.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | listening for start, reader enabled in byte mode
// ADDR      | shifting in address byte
// ADDR_ACK  | writer drives ACK for matched address
// DATA      | shifting in a data byte
// DATA_ACK  | writer drives ACK (accepted) or NACK (overrun)
// HANDOFF   | transmit path owns the bus until tx_done
// WAIT_STOP | ignoring traffic until stop or repeated start
module i2c_slave_rx_sequencer #(
    parameter bit          GEN_CALL_EN = 1'b0,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] own_addr,
    output logic       rd_en,
    output logic       rd_is_byte,
    input  logic       rd_ld,
    input  logic       rd_data,
    input  logic       get_start,
    input  logic       get_stop,
    input  logic       rd_bus_err,
    input  logic       rd_finish,
    output logic       wr_en,
    output logic       wr_bit,
    input  logic       wr_finish,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       tx_req,
    input  logic       tx_done,
    output logic       addr_hit,
    output logic       busy,
    output logic       overrun,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_HANDOFF, S_WAIT_STOP
    } state_t;

    state_t      r_state;
    logic        r_gap;
    logic        r_rd_en;
    logic        r_wr_en;
    logic        r_wr_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_tx_req;
    logic        r_addr_hit;
    logic        r_overrun;
    logic        r_err;
    logic [15:0] r_tmo_cnt;

    state_t      w_state_nx;
    logic [7:0]  w_shift_nx;
    logic        w_addr_match;
    logic        w_tmo;
    logic        w_restart;
    logic        w_start;
    logic        w_err_nx;
    logic        w_tx_req_nx;
    logic        w_load;
    logic        w_ack;
    logic        w_nack;
    logic        w_hit_set;
    logic        w_trans;
    logic        w_in_ack;

    assign w_shift_nx   = (rd_ld && !r_gap && (r_state == S_ADDR || r_state == S_DATA))
                          ? {r_shift[6:0], rd_data} : r_shift;
    assign w_addr_match = (w_shift_nx[7:1] == own_addr) || (GEN_CALL_EN && (w_shift_nx == 8'h00));
    assign w_tmo        = (TIMEOUT_CYC != 16'd0) && (r_tmo_cnt == TIMEOUT_CYC);
    assign w_in_ack     = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);

    // Inputs are ignored during the gap cycle: reader/writer flags are still stale.
    always_comb begin
        w_state_nx  = r_state;
        w_restart   = 1'b0;
        w_start     = 1'b0;
        w_err_nx    = 1'b0;
        w_tx_req_nx = 1'b0;
        w_load      = 1'b0;
        w_ack       = 1'b0;
        w_nack      = 1'b0;
        w_hit_set   = 1'b0;
        if (!r_gap) begin
            case (r_state)
                S_IDLE: begin
                    if (get_start) begin
                        w_state_nx = S_ADDR;
                        w_start    = 1'b1;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rd_bus_err) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_WAIT_STOP;
                    end else if (get_start) begin
                        w_state_nx = S_ADDR;
                        w_restart  = 1'b1;
                        w_start    = 1'b1;
                    end else if (get_stop) begin
                        w_state_nx = S_IDLE;
                    end else if (rd_finish) begin
                        if (r_state == S_ADDR) begin
                            if (w_addr_match) begin
                                w_state_nx = S_ADDR_ACK;
                                w_ack      = 1'b1;
                                w_hit_set  = 1'b1;
                            end else begin
                                w_state_nx = S_WAIT_STOP;
                            end
                        end else begin
                            w_state_nx = S_DATA_ACK;
                            if (!r_rx_valid) begin
                                w_load = 1'b1;
                                w_ack  = 1'b1;
                            end else begin
                                w_nack = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (get_start) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_ADDR;
                        w_start    = 1'b1;
                    end else if (w_tmo) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else if (wr_finish) begin
                        if (r_state == S_ADDR_ACK) begin
                            if (r_shift[0]) begin
                                w_tx_req_nx = 1'b1;
                                w_state_nx  = S_HANDOFF;
                            end else begin
                                w_state_nx  = S_DATA;
                            end
                        end else begin
                            w_state_nx = r_wr_bit ? S_WAIT_STOP : S_DATA;
                        end
                    end
                end
                S_HANDOFF: begin
                    if (tx_done) w_state_nx = S_WAIT_STOP;
                end
                S_WAIT_STOP: begin
                    if (get_start) begin
                        w_state_nx = S_ADDR;
                        w_start    = 1'b1;
                    end else if (get_stop) begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // A repeated start in ADDR counts as a transition so the reader restarts too.
    assign w_trans = (w_state_nx != r_state) || w_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gap      <= 1'b0;
            r_rd_en    <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_bit   <= 1'b0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_addr_hit <= 1'b0;
            r_overrun  <= 1'b0;
            r_err      <= 1'b0;
            r_tmo_cnt  <= 16'd0;
        end else begin
            r_state  <= w_state_nx;
            r_gap    <= w_trans;
            r_rd_en  <= !w_trans && (r_state == S_IDLE || r_state == S_ADDR ||
                                     r_state == S_DATA || r_state == S_WAIT_STOP);
            r_wr_en  <= !w_trans && w_in_ack;
            r_shift  <= w_start ? 8'h00 : w_shift_nx;
            r_tx_req <= w_tx_req_nx;
            r_err    <= w_err_nx;
            if (w_ack)       r_wr_bit <= 1'b0;
            else if (w_nack) r_wr_bit <= 1'b1;
            if (w_load) begin
                r_rx_data  <= w_shift_nx;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_hit_set)
                r_addr_hit <= 1'b1;
            else if (w_trans && (w_state_nx == S_IDLE || w_state_nx == S_ADDR))
                r_addr_hit <= 1'b0;
            if (w_nack)       r_overrun <= 1'b1;
            else if (w_start) r_overrun <= 1'b0;
            if (w_trans)
                r_tmo_cnt <= 16'd0;
            else if (w_in_ack && r_tmo_cnt != 16'hFFFF)
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign rd_en      = r_rd_en;
    assign rd_is_byte = 1'b1;
    assign wr_en      = r_wr_en;
    assign wr_bit     = r_wr_bit;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_req     = r_tx_req;
    assign addr_hit   = r_addr_hit;
    assign busy       = (r_state != S_IDLE);
    assign overrun    = r_overrun;
    assign err        = r_err;

endmodule

// File: doc/i2c_slave_rx_sequencer.md
Name: i2c_slave_rx_sequencer

Overview:
- Slave-side controller that sequences the bit/byte reader and the single-bit writer to receive I2C write transfers.
- Receives the address byte, compares it against own address, sequences ACK/NACK, and shifts data bytes in.
- Hands each data byte to the register/FIFO layer over a valid/ready handshake.
- On a matched read request (R/W=1), hands the bus to the transmit path.

Parameters:
- GEN_CALL_EN, 0: 1 = also ACK address 7'h00 (general call, write only).
- TIMEOUT_CYC, 16'd4095: max clk cycles waiting for wr_finish before declaring error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- own_addr  in  7  slave address, sampled when address byte completes
- rd_en  out  1  enable to bit/byte reader
- rd_is_byte  out  1  reader mode, 1 = byte, 0 = bit
- rd_ld  in  1  reader shift strobe (one cycle per SCL fall)
- rd_data  in  1  reader sampled SDA bit
- get_start  in  1  reader start/repeated-start detect
- get_stop  in  1  reader stop detect
- rd_bus_err  in  1  reader misplaced start/stop
- rd_finish  in  1  reader done, sticky while rd_en
- wr_en  out  1  enable to bit writer
- wr_bit  out  1  bit to drive, 0 = ACK, 1 = NACK
- wr_finish  in  1  writer done, sticky while wr_en
- rx_data  out  8  received data byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts rx_data
- tx_req  out  1  one-cycle pulse: matched read, transmit path takes over
- tx_done  in  1  transmit path finished (NACK or stop seen)
- addr_hit  out  1  high from matched address ACK until stop/repeated start
- busy  out  1  state != IDLE
- overrun  out  1  sticky: byte NACKed because rx_valid still high; cleared by reset or next start
- err  out  1  one-cycle pulse on bus error or ACK timeout

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, shift reg=0, rx_data=0; all outputs 0 except rd_en=1, rd_is_byte=1.
- States:
  - IDLE: rd_en=1, byte mode, listening. get_start -> ADDR.
  - ADDR: byte read. Shift reg <= {shift[6:0], rd_data} on each rd_ld. On rd_finish, compare shift[7:1] with own_addr, or with 0 when GEN_CALL_EN=1 and shift[0]=0. Match -> ADDR_ACK with wr_bit=0; no match -> WAIT_STOP.
  - ADDR_ACK: wr_en=1, wait for wr_finish. Then: R/W=0 -> DATA; R/W=1 -> pulse tx_req, go to HANDOFF.
  - DATA: byte read. On rd_finish: if rx_valid=0, load rx_data, set rx_valid, wr_bit=0; else wr_bit=1 and set overrun. Then -> DATA_ACK.
  - DATA_ACK: wr_en=1. On wr_finish: wr_bit=0 -> DATA; wr_bit=1 -> WAIT_STOP.
  - HANDOFF: rd_en=0, wr_en=0. tx_done -> WAIT_STOP.
  - WAIT_STOP: rd_en=1, byte mode. get_stop -> IDLE; get_start -> ADDR.
- Reader/writer reset gap: rd_en and wr_en are registered. Every state transition forces both low for exactly one cycle so the sticky finish flags and bit counter clear. get_start/get_stop are ignored in that gap cycle.
- Start/stop priority in ADDR and DATA (rd_en=1): rd_bus_err first -> pulse err, go to WAIT_STOP. Otherwise get_start -> ADDR (repeated start), then get_stop -> IDLE. Both clear addr_hit.
- Start while in ADDR_ACK or DATA_ACK -> err pulse, go to ADDR.
- rx handshake: rx_valid clears on the cycle rx_valid & rx_ready. Load and accept in the same cycle is impossible, because load requires rx_valid=0.
- Timeout: a 16-bit counter resets on entry to ADDR_ACK/DATA_ACK and increments each cycle. At count == TIMEOUT_CYC: pulse err, go to IDLE.
- rx_valid and rx_data persist across stop; only consumption or rst clears them.

Test Plan:
- own_addr=7'h3A; bus START, 0x74, data 0xA5, 0x5A, STOP; rx_ready=1 -> two ACKs (wr_bit=0); rx_data 0xA5 then 0x5A with one rx_valid each; state returns to IDLE, busy=0.
- own_addr=7'h3A; START, 0x76 -> no match, no wr_en; stays WAIT_STOP through following bytes; IDLE after STOP; addr_hit never 1.
- Match write; rx_ready=0; two data bytes -> first ACKed, rx_valid=1; second NACKed (wr_bit=1), overrun=1, rx_data still first byte.
- START, 0x75 (read, own 7'h3A) -> ACK, one-cycle tx_req, rd_en=wr_en=0; tx_done -> WAIT_STOP; STOP -> IDLE.
- Repeated START after data bit 4 (rd_bus_err=1) -> err pulse, WAIT_STOP. Separately, hold wr_finish=0 with TIMEOUT_CYC=8 -> err after 8 cycles, IDLE.
- GEN_CALL_EN=1, START, 0x00 -> ACK. GEN_CALL_EN=0, same stimulus -> no ACK. rst mid-DATA -> IDLE next cycle, outputs at reset values.
